// File: rtl/rv32i_bus_pkg.sv
// Shared types and constants for the rv32i memory bridge: FSM states,
// bus widths and the NOP word returned on aborted reads.
package rv32i_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_MW = BUS_DW / 8;

  localparam logic [BUS_DW-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/rv32i_mem_bridge_t_if.sv
// Registered req/ack memory bus between the bridge (master) and a memory
// slave; request fields stay stable from request until acknowledge.
interface rv32i_mem_bridge_t_if;
  import rv32i_bus_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_MW-1:0] bus_wmask;
  logic [BUS_DW-1:0] bus_wdata;
  logic [BUS_DW-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wmask,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wmask,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/rv32i_bus_watchdog_t.sv
// Request watchdog: counts un-acked REQ cycles and flags expiry on the cycle
// the count reaches TIMEOUT-1. TIMEOUT=0 removes the counter entirely.
module rv32i_bus_watchdog_t #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
          cnt_next = '0;
        end else if (run && (cnt_reg != LAST)) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign expire = run && (cnt_reg == LAST);
    end else begin : g_off
      logic unused_wd_inputs;
      assign unused_wd_inputs = ^{clk, reset_n, clear, run};
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/rv32i_mem_bridge_t.sv
// Converts the rv32i_cpu_t combinational memory port into one registered
// req/ack bus transaction per CPU step. Optional macro RD_REUSE_EN skips the
// bus for a repeated read of the last successfully read word.
module rv32i_mem_bridge_t
  import rv32i_bus_pkg::*;
#(
  parameter int                TIMEOUT  = 64,
  parameter logic [BUS_DW-1:0] ERR_DATA = NOP_INSN
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BUS_AW-1:0]   cpu_addr,
  input  logic [BUS_MW-1:0]   cpu_wmask,
  input  logic [BUS_DW-1:0]   cpu_wdata,
  output logic [BUS_DW-1:0]   cpu_rdata,
  output logic                cpu_hold,
  rv32i_mem_bridge_t_if.master bus,
  output logic                err
);

  bridge_state_t     state_reg, state_next;
  logic              bus_req_reg, bus_req_next;
  logic              bus_we_reg, bus_we_next;
  logic [BUS_AW-1:0] bus_addr_reg, bus_addr_next;
  logic [BUS_MW-1:0] bus_wmask_reg, bus_wmask_next;
  logic [BUS_DW-1:0] bus_wdata_reg, bus_wdata_next;
  logic [BUS_DW-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic              err_reg, err_next;
  logic              wd_expire;
  logic              rd_hit;

  // Bus addresses are word aligned; the byte offset is carried by the mask.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  rv32i_bus_watchdog_t #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg != REQ),
    .run     ((state_reg == REQ) && !bus.bus_ack),
    .expire  (wd_expire)
  );

`ifdef RD_REUSE_EN
  logic        reuse_valid_reg, reuse_valid_next;
  logic [29:0] reuse_addr_reg, reuse_addr_next;

  always_comb begin
    reuse_valid_next = reuse_valid_reg;
    reuse_addr_next  = reuse_addr_reg;
    if ((state_reg == IDLE) && (cpu_wmask != '0)) begin
      reuse_valid_next = 1'b0;
    end else if (state_reg == REQ) begin
      if (bus.bus_ack && !bus_we_reg) begin
        reuse_valid_next = 1'b1;
        reuse_addr_next  = bus_addr_reg[31:2];
      end else if (wd_expire) begin
        reuse_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reuse_valid_reg <= 1'b0;
      reuse_addr_reg  <= '0;
    end else begin
      reuse_valid_reg <= reuse_valid_next;
      reuse_addr_reg  <= reuse_addr_next;
    end
  end

  assign rd_hit = reuse_valid_reg && (cpu_wmask == '0) &&
                  (cpu_addr[31:2] == reuse_addr_reg);
`else
  assign rd_hit = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wmask_next = bus_wmask_reg;
    bus_wdata_next = bus_wdata_reg;
    cpu_rdata_next = cpu_rdata_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        if (rd_hit) begin
          state_next = DONE;
        end else begin
          bus_addr_next  = {cpu_addr[31:2], 2'b00};
          bus_we_next    = (cpu_wmask != '0);
          bus_wmask_next = cpu_wmask;
          bus_wdata_next = cpu_wdata;
          bus_req_next   = 1'b1;
          state_next     = REQ;
        end
      end
      REQ: begin
        // A late ack on the expiry cycle still completes normally.
        if (bus.bus_ack) begin
          bus_req_next = 1'b0;
          if (!bus_we_reg) begin
            cpu_rdata_next = bus.bus_rdata;
          end
          state_next = DONE;
        end else if (wd_expire) begin
          bus_req_next = 1'b0;
          if (!bus_we_reg) begin
            cpu_rdata_next = ERR_DATA;
          end
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wmask_reg <= '0;
      bus_wdata_reg <= '0;
      cpu_rdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wmask_reg <= bus_wmask_next;
      bus_wdata_reg <= bus_wdata_next;
      cpu_rdata_reg <= cpu_rdata_next;
      err_reg       <= err_next;
    end
  end

  assign cpu_hold      = (state_reg != DONE);
  assign cpu_rdata     = cpu_rdata_reg;
  assign err           = err_reg;
  assign bus.bus_req   = bus_req_reg;
  assign bus.bus_we    = bus_we_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_wmask = bus_wmask_reg;
  assign bus.bus_wdata = bus_wdata_reg;

endmodule

// File: doc/rv32i_mem_bridge_t.md
Name: rv32i_mem_bridge_t

Overview:
Sits directly downstream of the rv32i_cpu_t memory port and converts its "combinational memory plus hold" interface into a registered req/ack bus for slow or multi-cycle memories. Each CPU step becomes one bus transaction: a read, or a masked write when the write mask is non-zero. The bridge stalls the CPU via cpu_hold until data is valid or the write is accepted. An optional watchdog aborts hung transactions.

Parameters:
TIMEOUT, 64, number of cycles a request may wait in REQ for bus_ack before abort; 0 disables the watchdog.
ERR_DATA, 32'h00000013, read data returned on timeout (RV32I NOP).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  32  CPU memory address (out_mem_addr)
cpu_wmask  in  4  CPU byte write mask; 0 means read
cpu_wdata  in  32  CPU lane-shifted store data
cpu_rdata  out  32  word-aligned read data to CPU in_data
cpu_hold  out  1  stall to CPU hold
bus_req  out  1  bus request, held until ack
bus_we  out  1  1 = write transaction
bus_addr  out  32  word address {cpu_addr[31:2],2'b00}
bus_wmask  out  4  byte enables for writes
bus_wdata  out  32  write data
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  transaction complete
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cpu_hold=1, cpu_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wmask=0, bus_wdata=0, err=0, watchdog counter=0. A transaction in flight is abandoned; bus_req drops immediately. Slaves must tolerate this.
- States: IDLE, REQ, DONE. cpu_hold = (state != DONE), combinational from state.
- IDLE: register bus_addr, bus_we=(cpu_wmask!=0), bus_wmask=cpu_wmask, bus_wdata=cpu_wdata. Set bus_req=1 and go to REQ.
- REQ: bus_req and all bus_* fields are stable.
  - On bus_ack=1: bus_req=0. Latch cpu_rdata=bus_rdata on reads; cpu_rdata is unchanged on writes. Go to DONE.
  - Watchdog (TIMEOUT>0): counter increments each REQ cycle without ack. If it reaches TIMEOUT-1 with no ack: bus_req=0, cpu_rdata=ERR_DATA on reads, err=1, go to DONE.
  - If ack and expiry occur in the same cycle, ack wins and err is unchanged.
  - The counter clears on REQ entry.
- DONE: cpu_hold=0 for exactly one cycle; the CPU consumes cpu_rdata or commits its store. Next state is IDLE.
- Latency: zero-wait slave (ack in first REQ cycle) gives 3 cycles per CPU step (IDLE, REQ, DONE). Each wait cycle adds one.
- bus_ack outside REQ is ignored.
- The CPU also issues reads during non-memory EXEC steps. The bridge performs them anyway, so reads must be side-effect free.
- cpu_rdata holds its value outside DONE.
- err is cleared only by reset.

Optional Feature:
RD_REUSE_EN.
- With the macro defined: the bridge keeps a valid bit and the word address of the last completed non-error read. In IDLE, if cpu_wmask==0, valid=1 and cpu_addr[31:2] matches, it goes directly to DONE without a bus transaction (2-cycle step) and cpu_rdata is unchanged.
- Any write, timeout, or reset clears valid.
- Without the macro: every step issues a bus transaction, as above.

Decomposition:
- Package rv32i_bus_pkg: state enum (IDLE/REQ/DONE), NOP constant 32'h00000013, bus width constants.
- One sub-module, rv32i_bus_watchdog_t: load/clear counter with expire output, parameterised by TIMEOUT, tied off when TIMEOUT=0.

Test Plan:
- Reset with bus_ack=1 held: cpu_hold=1, bus_req=0, err=0. First bus_req rises 1 cycle after reset_n deasserts.
- Read cpu_addr=0x00010076, wmask=0, zero-wait slave returns 0x12345678: bus_addr=0x00010074, bus_we=0, cpu_hold low in cycle 3 only, cpu_rdata=0x12345678.
- Write cpu_addr=0x102, wmask=4'b1100, wdata=0xBEEF0000, slave acks after 5 wait cycles: bus_we=1, bus_wmask=4'b1100, fields stable through all 6 REQ cycles, cpu_hold low one cycle after ack.
- Silent slave, TIMEOUT=8, read: bus_req drops after 8 REQ cycles, cpu_rdata=0x00000013, err=1 and stays 1 through later successful transactions.
- Ack arriving on the expiry cycle: cpu_rdata=bus_rdata, err stays 0.
- reset_n pulsed low mid-REQ: bus_req=0 and cpu_hold=1 asynchronously. Under RD_REUSE_EN, a repeated read of the same word skips the bus (no bus_req, hold low after 1 cycle), and a write to that word forces the next read onto the bus.
